// File: rtl/fetch_ctrl.sv
// Fetch sequencer for the 3BC processor: owns the PC, registers fetched words,
// redirects taken branches through a 32-entry target LUT and stops on the halt word.
module fetch_ctrl #(
    parameter int A     = 10,
    parameter int W     = 9,
    parameter int LUT_N = 5,
    parameter int CW    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stall,
    input  logic [W-1:0]     InstOut,
    output logic [A-1:0]     InstAddress,
    output logic [W-1:0]     Inst,
    output logic             InstValid,
    input  logic             BranchTaken,
    input  logic [LUT_N-1:0] BranchIdx,
    input  logic             LutWe,
    input  logic [LUT_N-1:0] LutWaddr,
    input  logic [A-1:0]     LutWdata,
    output logic             Busy,
    output logic             Done,
    output logic [CW-1:0]    CycleCount,
    output logic [1:0]       StateDbg
);

    // Handshake: Stall is a level hold from the datapath; BranchTaken/BranchIdx
    // are sampled only on a RUN edge with Stall low, and the datapath keeps them
    // asserted until then. Start is sampled only in IDLE or HALTED.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [W-1:0]  HALT_WORD = {W{1'b1}};
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam int            LUT_SIZE  = 2 ** LUT_N;

    state_t          state_q, state_d;
    logic [A-1:0]    pc_q, pc_d;
    logic [W-1:0]    inst_q, inst_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [A-1:0]    lut_q [LUT_SIZE];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                pc_d    = '0;
                valid_d = 1'b0;
                if (Start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!Stall) begin
                    // A taken branch flushes whatever was fetched this cycle, halt word included.
                    if (BranchTaken) begin
                        pc_d    = lut_q[BranchIdx];
                        valid_d = 1'b0;
                    end else begin
                        inst_d  = InstOut;
                        valid_d = 1'b1;
                        if (InstOut == HALT_WORD) begin
                            state_d = S_HALTED;
                        end else begin
                            pc_d = pc_q + A'(1);
                        end
                    end
                end
            end
            S_HALTED: begin
                valid_d = 1'b0;
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Non-blocking write means a same-edge branch read sees the old entry.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < LUT_SIZE; i++) begin
                lut_q[i] <= '0;
            end
        end else if (LutWe) begin
            lut_q[LutWaddr] <= LutWdata;
        end
    end

    assign InstAddress = pc_q;
    assign Inst        = inst_q;
    assign InstValid   = valid_q;
    assign CycleCount  = cnt_q;
    assign Busy        = (state_q == S_RUN);
    assign Done        = (state_q == S_HALTED);
    assign StateDbg    = state_q;

endmodule
